// File: rtl/tata_instr_fetch_pkg.sv
// tata_fetch_pkg: shared types and AXI constants for the instruction fetcher.
//   fetch_state_e : fetcher FSM states
//   AXI_*         : fixed AR field encodings and OKAY response
//   PAGE_BYTES    : AXI 4 KB boundary that no burst may cross
//   umin()        : unsigned 32-bit minimum used for burst sizing
package tata_fetch_pkg;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES     = 4096;

  function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tata_instr_fetch_if.sv
// tata_instr_fetch_if: AXI4 read-only (AR + R) channel bundle.
//   master modport : the fetcher (drives AR, rready)
//   slave  modport : instruction memory (drives arready, R)
interface tata_instr_fetch_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [2:0]        arprot;
  logic [3:0]        arcache;
  logic [3:0]        aruser;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arprot, arcache, aruser, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arprot, arcache, aruser, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/tata_sync_fifo.sv
// tata_sync_fifo: single-clock first-word-fall-through FIFO.
//   push_i/wdata_i : write side (ignored when full)
//   pop_i/rdata_o  : read side; rdata_o is the head, forced to 0 when empty
//   empty_o/full_o/count_o : occupancy
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module tata_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/tata_instr_fetch.sv
// tata_instr_fetch: job-driven AXI4 instruction read master.
//   ap_clk/ap_resetn          : clock, async active-low reset
//   start_i/base_addr_i/instr_num_i : job request (sampled in IDLE)
//   busy_o/done_o/err_o       : job status (err_o sticky until next start)
//   m_axi_instr               : AXI AR/R master
//   instr_valid_o/ready_i/data_o : FWFT instruction stream
// Optional: TATA_INSTR_FETCH_PERF_EN adds stall_ar_cycles_o / stall_out_cycles_o.
// A burst is only issued once FIFO space for every beat is reserved, so rready
// is simply "any beats outstanding" and never throttles a burst.
module tata_instr_fetch
  import tata_fetch_pkg::*;
#(
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 64,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              ap_clk,
  input  logic              ap_resetn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [31:0]       instr_num_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  tata_instr_fetch_if.master m_axi_instr,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_data_o
`ifdef TATA_INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_ar_cycles_o,
  output logic [31:0]       stall_out_cycles_o
`endif
);
  localparam int BEAT_SHIFT = $clog2(DATA_W / 8);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int LEN_W      = $clog2(MAX_BURST) + 1;
  localparam int PAGE_OFF_W = $clog2(PAGE_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       left_q, left_d;
  logic [CNT_W-1:0]  rsv_q, rsv_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [LEN_W-1:0]  rbeat_q, rbeat_d;

  logic [31:0]       page_room, burst_len, free_beats, ar_beats;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [LEN_W-1:0]  cur_arlen;
  logic              fifo_empty, ar_hs, r_hs, exp_last, start_ok;
  logic              unused_data_full, unused_len_empty, unused_len_full;
  logic [CNT_W-1:0]  unused_len_cnt;

  assign m_axi_instr.arvalid = arvalid_q;
  assign m_axi_instr.araddr  = addr_q;
  assign m_axi_instr.arlen   = arlen_q;
  assign m_axi_instr.arsize  = AXI_SIZE_8B;
  assign m_axi_instr.arburst = AXI_BURST_INCR;
  assign m_axi_instr.arprot  = 3'd0;
  assign m_axi_instr.arcache = AXI_CACHE_DEF;
  assign m_axi_instr.aruser  = 4'd0;
  assign m_axi_instr.rready  = (rsv_q != '0);

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign instr_valid_o = ~fifo_empty;

  assign ar_hs    = arvalid_q & m_axi_instr.arready;
  assign r_hs     = m_axi_instr.rvalid & m_axi_instr.rready;
  assign start_ok = (state_q == IDLE) & start_i;
  assign ar_beats = 32'(arlen_q) + 32'd1;
  // beats until the next 4 KB boundary (1 .. PAGE_BYTES/beat)
  assign page_room  = (32'(PAGE_BYTES) - 32'(addr_q[PAGE_OFF_W-1:0])) >> BEAT_SHIFT;
  assign burst_len  = umin(umin(32'(MAX_BURST), left_q), page_room);
  assign free_beats = 32'(FIFO_DEPTH) - 32'(fifo_cnt) - 32'(rsv_q);
  // the length FIFO tracks outstanding bursts so rlast can be checked per beat
  assign exp_last   = (rbeat_q == cur_arlen);

  tata_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk(ap_clk), .rst_n(ap_resetn),
    .push_i(r_hs), .wdata_i(m_axi_instr.rdata),
    .pop_i(instr_ready_i), .rdata_o(instr_data_o),
    .empty_o(fifo_empty), .full_o(unused_data_full), .count_o(fifo_cnt)
  );

  tata_sync_fifo #(.WIDTH(LEN_W), .DEPTH(FIFO_DEPTH)) u_len_fifo (
    .clk(ap_clk), .rst_n(ap_resetn),
    .push_i(ar_hs), .wdata_i(LEN_W'(arlen_q)),
    .pop_i(r_hs & exp_last), .rdata_o(cur_arlen),
    .empty_o(unused_len_empty), .full_o(unused_len_full), .count_o(unused_len_cnt)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    busy_d    = busy_q & ~done_q;   // busy drops together with the done pulse
    done_d    = 1'b0;
    err_d     = err_q;
    rbeat_d   = rbeat_q;
    rsv_d     = rsv_q + (ar_hs ? CNT_W'(ar_beats) : '0) - (r_hs ? CNT_W'(1) : '0);

    if (r_hs) begin
      if (m_axi_instr.rresp != AXI_RESP_OKAY || m_axi_instr.rlast != exp_last) err_d = 1'b1;
      rbeat_d = exp_last ? '0 : rbeat_q + LEN_W'(1);
    end

    case (state_q)
      IDLE: if (start_i) begin
        addr_d  = base_addr_i;
        left_d  = instr_num_i;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = (instr_num_i == 32'd0) ? DONE : CALC;
      end
      CALC: if (free_beats >= burst_len) begin
        arlen_d   = 8'(burst_len - 32'd1);
        arvalid_d = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: if (m_axi_instr.arready) begin
        arvalid_d = 1'b0;
        addr_d    = addr_q + ADDR_W'(ar_beats << BEAT_SHIFT);
        left_d    = left_q - ar_beats;
        state_d   = (left_d != 32'd0) ? CALC : DRAIN;
      end
      DRAIN: if (rsv_q == '0 && fifo_empty) state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_resetn) begin
    if (!ap_resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      rsv_q     <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rbeat_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      rsv_q     <= rsv_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rbeat_q   <= rbeat_d;
    end
  end

`ifdef TATA_INSTR_FETCH_PERF_EN
  logic [31:0] stall_ar_q, stall_ar_d, stall_out_q, stall_out_d;

  assign stall_ar_cycles_o  = stall_ar_q;
  assign stall_out_cycles_o = stall_out_q;

  always_comb begin
    stall_ar_d  = stall_ar_q;
    stall_out_d = stall_out_q;
    if (start_ok) begin
      stall_ar_d  = '0;
      stall_out_d = '0;
    end else begin
      if (arvalid_q && !m_axi_instr.arready && stall_ar_q != '1) stall_ar_d = stall_ar_q + 32'd1;
      if (instr_valid_o && !instr_ready_i && stall_out_q != '1) stall_out_d = stall_out_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_resetn) begin
    if (!ap_resetn) begin
      stall_ar_q  <= '0;
      stall_out_q <= '0;
    end else begin
      stall_ar_q  <= stall_ar_d;
      stall_out_q <= stall_out_d;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif
endmodule

// File: tb/tb_tata_instr_fetch.sv
// Bench for tata_instr_fetch: table of directed jobs, hand-written corner
// sequences (num=0 timing, output backpressure, sticky error, reset mid-burst)
// and random jobs against a burst-list / address-stream reference model.
module tb_tata_instr_fetch;
  localparam int AW = 40;
  localparam int DW = 64;

  logic          ap_clk = 1'b0;
  logic          ap_resetn = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [31:0]   instr_num_i = '0;
  logic          busy_o, done_o, err_o, instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic [DW-1:0] instr_data_o;
`ifdef TATA_INSTR_FETCH_PERF_EN
  logic [31:0]   stall_ar_cycles, stall_out_cycles;
`endif

  tata_instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  tata_instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .FIFO_DEPTH(32)) dut (
    .ap_clk(ap_clk), .ap_resetn(ap_resetn), .start_i(start_i),
    .base_addr_i(base_addr_i), .instr_num_i(instr_num_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_axi_instr(axi),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_data_o(instr_data_o)
`ifdef TATA_INSTR_FETCH_PERF_EN
    , .stall_ar_cycles_o(stall_ar_cycles), .stall_out_cycles_o(stall_out_cycles)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {logic [AW-1:0] addr; int len;} burst_t;
  typedef struct {
    logic [AW-1:0] base; int num; int err_beat;
    int exp_nar; int exp_len0; logic [AW-1:0] exp_addr1; bit exp_err;
  } vec_t;

  burst_t        pend[$];
  burst_t        got_ar[$];
  logic [DW-1:0] got_ins[$];
  int beat_idx = 0, outstanding = 0, gbeat = 0, err_beat = -1;
  int n_done = 0, proto_err = 0;
  int ar_p = 100, rv_p = 100, out_p = 100;
  bit start_req = 0, prev_ar_stall = 0;
  logic [AW-1:0] prev_araddr = '0;
  logic [7:0]    prev_arlen = '0;
  logic smp_busy = 0, smp_done = 0, smp_err = 0;
  int n_chk = 0, n_fail = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {24'hC0FFEE, a};
  endfunction

  function automatic bit coin(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock: sample at negedge, drive the memory/sink, account handshakes.
  task automatic cycle();
    bit ar_hs, r_hs, o_hs;
    @(negedge ap_clk);
    smp_busy = busy_o; smp_done = done_o; smp_err = err_o;
    if (axi.rready !== (outstanding != 0)) proto_err++;
    if (prev_ar_stall && (axi.arvalid !== 1'b1 || axi.araddr !== prev_araddr || axi.arlen !== prev_arlen))
      proto_err++;
    if (done_o === 1'b1) n_done++;
    start_i   = start_req;
    start_req = 0;
    axi.arready = coin(ar_p);
    if (pend.size() != 0 && coin(rv_p)) begin
      axi.rvalid = 1'b1;
      axi.rdata  = mem_word(pend[0].addr + AW'(beat_idx * 8));
      axi.rlast  = (beat_idx == pend[0].len - 1);
      axi.rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
    end else begin
      axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    end
    instr_ready_i = coin(out_p);
    ar_hs = axi.arvalid && axi.arready;
    r_hs  = axi.rvalid && axi.rready;
    o_hs  = instr_valid_o && instr_ready_i;
    prev_ar_stall = axi.arvalid && !axi.arready;
    prev_araddr   = axi.araddr;
    prev_arlen    = axi.arlen;
    if (r_hs) begin
      beat_idx++; gbeat++; outstanding--;
      if (beat_idx == pend[0].len) begin
        void'(pend.pop_front());
        beat_idx = 0;
      end
    end
    if (ar_hs) begin
      pend.push_back('{addr: axi.araddr, len: int'(axi.arlen) + 1});
      got_ar.push_back('{addr: axi.araddr, len: int'(axi.arlen) + 1});
      outstanding += int'(axi.arlen) + 1;
    end
    if (o_hs) got_ins.push_back(instr_data_o);
    @(posedge ap_clk);
  endtask

  task automatic begin_job(input logic [AW-1:0] base, input int num, input int eb);
    got_ar.delete(); got_ins.delete();
    n_done = 0; proto_err = 0; gbeat = 0; err_beat = eb;
    base_addr_i = base; instr_num_i = num; start_req = 1;
    cycle();
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin cycle(); k++; end
    chk($sformatf("%s done within budget", name), 64'(n_done != 0), 64'd1);
    repeat (3) cycle();
    chk($sformatf("%s done pulse count", name), 64'(n_done), 64'd1);
  endtask

  // Reference: burst list from min(16, left, room-to-4KB), then address stream.
  task automatic check_job(input string name, input logic [AW-1:0] base, input int num, input bit exp_err);
    burst_t exp_ar[$];
    logic [AW-1:0] a = base;
    int left = num, mism = 0, len, room;
    while (left > 0) begin
      room = (4096 - int'(a % 4096)) / 8;
      len = 16;
      if (left < len) len = left;
      if (room < len) len = room;
      exp_ar.push_back('{addr: a, len: len});
      a = a + AW'(len * 8);
      left -= len;
    end
    chk($sformatf("%s AR count", name), 64'(got_ar.size()), 64'(exp_ar.size()));
    for (int i = 0; i < got_ar.size() && i < exp_ar.size(); i++)
      if (got_ar[i].addr !== exp_ar[i].addr || got_ar[i].len != exp_ar[i].len) mism++;
    chk($sformatf("%s AR mismatches", name), 64'(mism), 64'd0);
    chk($sformatf("%s instr count", name), 64'(got_ins.size()), 64'(num));
    mism = 0;
    for (int i = 0; i < got_ins.size(); i++)
      if (got_ins[i] !== mem_word(base + AW'(i * 8))) mism++;
    chk($sformatf("%s instr data mismatches", name), 64'(mism), 64'd0);
    chk($sformatf("%s protocol violations", name), 64'(proto_err), 64'd0);
    chk($sformatf("%s err_o", name), 64'(err_o), 64'(exp_err));
    chk($sformatf("%s busy_o idle", name), 64'(busy_o), 64'd0);
  endtask

  task automatic clear_mem();
    pend.delete(); beat_idx = 0; outstanding = 0; prev_ar_stall = 0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
    start_i = 1'b0; start_req = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [AW-1:0] b;
    int num, eb, k;
    bit [5:0] bd;

    vecs[0] = '{base: 40'h0,           num: 40, err_beat: -1, exp_nar: 3, exp_len0: 15, exp_addr1: 40'h80,   exp_err: 0};
    vecs[1] = '{base: 40'hFC0,         num: 16, err_beat: -1, exp_nar: 2, exp_len0: 7,  exp_addr1: 40'h1000, exp_err: 0};
    vecs[2] = '{base: 40'hFF8,         num: 3,  err_beat: -1, exp_nar: 2, exp_len0: 0,  exp_addr1: 40'h1000, exp_err: 0};
    vecs[3] = '{base: 40'hFF_FFFF_FFF0, num: 4, err_beat: -1, exp_nar: 2, exp_len0: 1,  exp_addr1: 40'h0,    exp_err: 0};
    vecs[4] = '{base: 40'h2000,        num: 1,  err_beat: -1, exp_nar: 1, exp_len0: 0,  exp_addr1: 40'h0,    exp_err: 0};
    vecs[5] = '{base: 40'h0,           num: 16, err_beat: 4,  exp_nar: 1, exp_len0: 15, exp_addr1: 40'h0,    exp_err: 1};

    clear_mem();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset outputs", 64'({busy_o, done_o, err_o, axi.arvalid, axi.rready, instr_valid_o,
                              instr_data_o != 0, axi.araddr != 0, axi.arlen != 0}), 64'd0);
    chk("AR constant fields", 64'({axi.arsize, axi.arburst, axi.arprot, axi.arcache, axi.aruser}),
        64'({3'd3, 2'b01, 3'd0, 4'b0011, 4'd0}));
    ap_resetn = 1'b1;

    // directed table, memory and sink always ready
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      ar_p = 100; rv_p = 100; out_p = 100;
      begin_job(vecs[v].base, vecs[v].num, vecs[v].err_beat);
      wait_done(nm, 2000);
      check_job(nm, vecs[v].base, vecs[v].num, vecs[v].exp_err);
      chk({nm, " AR count table"}, 64'(got_ar.size()), 64'(vecs[v].exp_nar));
      if (got_ar.size() > 0) chk({nm, " first arlen"}, 64'(got_ar[0].len - 1), 64'(vecs[v].exp_len0));
      if (got_ar.size() > 1) chk({nm, " second araddr"}, 64'(got_ar[1].addr), 64'(vecs[v].exp_addr1));
    end

    // error is sticky, then cleared by the next accepted start
    repeat (5) cycle();
    chk("err sticky", 64'(err_o), 64'd1);
    begin_job(40'h3000, 2, -1);
    cycle();
    chk("err cleared after start", 64'(smp_err), 64'd0);
    wait_done("err clear job", 500);
    check_job("err clear job", 40'h3000, 2, 0);

    // num = 0: busy/done timeline and no AR
    begin_job(40'h100, 0, -1);
    cycle(); bd[5:4] = {smp_busy, smp_done};
    cycle(); bd[3:2] = {smp_busy, smp_done};
    cycle(); bd[1:0] = {smp_busy, smp_done};
    chk("num0 busy/done timeline", 64'(bd), 64'(6'b10_11_00));
    repeat (3) cycle();
    chk("num0 AR count", 64'(got_ar.size()), 64'd0);
    chk("num0 done pulses", 64'(n_done), 64'd1);

    // downstream stalled: only two bursts fit, third follows once drained
    ar_p = 100; rv_p = 100; out_p = 0;
    begin_job(40'h0, 40, -1);
    repeat (150) cycle();
    chk("backpressure AR count while stalled", 64'(got_ar.size()), 64'd2);
    chk("backpressure instr_valid while stalled", 64'(instr_valid_o), 64'd1);
    chk("backpressure rready mid-burst", 64'(proto_err), 64'd0);
    out_p = 100;
    wait_done("backpressure", 2000);
    check_job("backpressure", 40'h0, 40, 0);

    // reset during the second burst, then a clean job
    ar_p = 100; rv_p = 40; out_p = 100;
    begin_job(40'h5000, 40, -1);
    k = 0;
    while (got_ar.size() < 2 && k < 500) begin cycle(); k++; end
    cycle();
    chk("reset-mid second AR seen", 64'(got_ar.size() >= 2), 64'd1);
    @(negedge ap_clk);
    ap_resetn = 1'b0;
    clear_mem();
    #1;
    chk("reset-mid outputs", 64'({busy_o, done_o, err_o, axi.arvalid, axi.rready, instr_valid_o,
                                  instr_data_o != 0, axi.araddr != 0, axi.arlen != 0}), 64'd0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_resetn = 1'b1;
    rv_p = 100;
    begin_job(40'h6000, 8, -1);
    wait_done("post-reset", 500);
    check_job("post-reset", 40'h6000, 8, 0);

    // random jobs with random handshake pressure
    for (int j = 0; j < 20; j++) begin
      string nm;
      nm = $sformatf("rnd%0d", j);
      b = AW'($urandom) << 12;
      if (coin(50)) b = b + AW'(4096 - 8 * int'($urandom_range(1, 40)));
      else          b = b + AW'(8 * int'($urandom_range(0, 511)));
      num = int'($urandom_range(1, 60));
      eb  = coin(30) ? int'($urandom_range(0, num - 1)) : -1;
      ar_p = int'($urandom_range(30, 100));
      rv_p = int'($urandom_range(30, 100));
      out_p = int'($urandom_range(30, 100));
      begin_job(b, num, eb);
      wait_done(nm, 5000);
      check_job(nm, b, num, eb >= 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
